bram_save_ctrl: RTL
===================

# bram_save_ctrl

Parametrised backup-RAM save/load sequencer between `hps_io`'s SD block interface and the cartridge backup RAM in `system`. It supports multiple save slots and partial loads sized from the image, plus an optional ack watchdog. It handles save-file arming, OSD-gated autosave and auto-load after ROM download. It drives `sd_lba`/`sd_rd`/`sd_wr`, and its `sd_lba[BLK_W-1:0]` feeds the BRAM address high bits.

## Interface
- `BLK_W`, 7: log2 blocks per slot; each block is 512 bytes.
- `SLOTS`, 1: number of save slots; `SLOT_W = max(1, $clog2(SLOTS))`.
- `TIMEOUT`, 24'd10_000_000: watchdog limit in clk_sys cycles (only with `BRAM_WDOG_EN`).
- `clk_sys  in  1`  system clock.
- `reset  in  1`  synchronous, active-high. Driven from RESET only, never from `bk_loading`.
- `downloading  in  1`  ROM download active.
- `img_mounted  in  1`  save image mount strobe.
- `img_readonly  in  1`  mounted image is read-only.
- `img_size  in  64`  mounted image size in bytes.
- `load_req  in  1`  manual load; rising edge acts.
- `save_req  in  1`  manual save; rising edge acts.
- `slot  in  SLOT_W`  slot select, sampled at start.
- `bk_change  in  1`  BRAM written by the game.
- `osd_status  in  1`  OSD open.
- `autosave  in  1`  autosave enable.
- `sd_ack  in  1`  block transfer acknowledge.
- `sd_lba  out  32`  block address.
- `sd_rd  out  1`  block read request.
- `sd_wr  out  1`  block write request.
- `bk_ena  out  1`  writable save file armed.
- `bk_loading  out  1`  load in progress; holds the system in reset.
- `bk_busy  out  1`  any transfer in progress.
- `sav_pending  out  1`  unsaved changes exist.
- `done  out  1`  one-cycle pulse at transfer end.
- `err  out  1`  sticky watchdog abort flag.

## Operation
- Reset values: all outputs 0; FSM in IDLE.
- `bk_ena`:
  - Cleared on the rising edge of `downloading`.
  - Set when `downloading & img_mounted & ~img_readonly`.
  - Set wins if both occur in the same cycle.
- `sav_pending`:
  - Set by `bk_change & ~osd_status`.
  - Cleared when any transfer starts.
  - Set wins if both occur in the same cycle.
- Start sources, checked only in IDLE with `bk_ena=1`, in priority order:
  1. Auto-load: falling edge of `downloading` with `img_size != 0`.
  2. Manual load: rising edge of `load_req`.
  3. Save: rising edge of `save_req`, or rising edge of `sav_pending & osd_status & autosave`.
- Edges seen while busy or with `bk_ena=0` are discarded, not queued.
- Addressing:
  - `base = slot << BLK_W`. Auto-load always uses slot 0.
  - `sd_lba = base + blk`, where `blk` is a BLK_W-bit counter starting at 0.
  - A slot value ≥ SLOTS clamps to SLOTS-1.
- Block count:
  - Save: always 2^BLK_W blocks.
  - Load: `n = clamp(ceil(img_size/512) - base, 0, 2^BLK_W)`. Computed in 64-bit arithmetic, saturating at 0.
  - If load `n==0`: no SD traffic, `done` pulses, `sd_lba` unchanged.
- FSM:
  - IDLE → REQ on start. Sets `bk_busy=1`, `bk_loading=is_load`, and `sd_rd=is_load`, `sd_wr=~is_load`.
  - REQ → ACK on `sd_ack` rising edge. `sd_rd`/`sd_wr` drop.
  - ACK → on `sd_ack` falling edge:
    - If `blk == n-1`: go to IDLE, clear `bk_busy`/`bk_loading`, pulse `done`.
    - Otherwise: `blk+1`, `sd_lba+1`, re-assert the request, back to REQ.
- `sd_rd` and `sd_wr` are never high together.
- `reset` mid-transfer: immediate IDLE, all requests dropped, no `done`.

## Timing
- Edge detectors use registered previous values; a start is acted on 1 cycle after the edge is visible.
- `sd_rd`/`sd_wr` rise 1 cycle after the start edge is detected. `sd_lba` is valid in the same cycle.
- The request falls 1 cycle after `sd_ack` rises.
- The next block's request and incremented `sd_lba` appear 1 cycle after `sd_ack` falls.
- `done` is coincident with the `bk_busy` fall, 1 cycle after the final `sd_ack` fall.
- The edge detectors still track inputs while busy.

## Configuration
- `BRAM_WDOG_EN` defined:
  - A counter runs in REQ and ACK, reset on every `sd_ack` edge.
  - At TIMEOUT: set `err`, drop requests, go to IDLE, clear `bk_busy`/`bk_loading`, no `done`.
  - A save abort re-sets `sav_pending`.
  - `err` clears at the next start or on `reset`.
- Undefined: no counter, `err` tied to 0, and the FSM waits indefinitely.

## Test plan
- **Arming:** download rise, then `img_mounted` with `img_readonly=0` → `bk_ena=1`. A read-only mount leaves `bk_ena=0`, and a `save_req` edge then produces no `sd_wr`.
- **Auto-load:** BLK_W=7, `img_size=65536`, download falls → 128 reads with `sd_lba` 0..127, `bk_loading` high throughout, then one `done` pulse.
- **Partial/multi-slot load:** SLOTS=4, BLK_W=7, `img_size=70000`:
  - `slot=1` load → 9 reads, `sd_lba` 128..136.
  - `slot=2` load → 0 reads, immediate `done`.
- **Autosave:**
  - `bk_change` with OSD closed → `sav_pending=1`.
  - `osd_status` rises with `autosave=1` → 128 writes starting at `sd_lba=0`; `sav_pending` clears at start.
  - A `bk_change` during the save with OSD closed re-sets it.
- **Simultaneous/reset:**
  - `load_req` and `save_req` edges in the same cycle → only the load runs.
  - `reset` asserted mid-block 5 → `sd_rd=sd_wr=0` next cycle, `bk_busy=0`, no `done`.
- **Watchdog (`BRAM_WDOG_EN`):** TIMEOUT=100, `sd_ack` held low → `err=1` at cycle 100, `bk_busy=0`, `sav_pending` restored for a save.

Source files
------------

// File: rtl/bram_save_ctrl_if.sv
// SD block-request bus between the backup-RAM save sequencer and hps_io.
// master: drives sd_lba/sd_rd/sd_wr, receives sd_ack; slave: the mirror.
interface bram_save_ctrl_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (
    output sd_lba, sd_rd, sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr,
    output sd_ack
  );
endinterface

// File: rtl/bram_save_ctrl.sv
// Backup-RAM save/load sequencer: multi-slot, partial loads, autosave.
// Ports: clk_sys/reset, download/mount/request/OSD inputs, sd bus (master
// modport), bk_ena/bk_loading/bk_busy/sav_pending/done/err status.
// Optional ack watchdog enabled by defining BRAM_WDOG_EN.
module bram_save_ctrl #(
  parameter int          BLK_W   = 7,
  parameter int          SLOTS   = 1,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000,
  localparam int         SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              downloading,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic              load_req,
  input  logic              save_req,
  input  logic [SLOT_W-1:0] slot,
  input  logic              bk_change,
  input  logic              osd_status,
  input  logic              autosave,
  bram_save_ctrl_if.master  sd,
  output logic              bk_ena,
  output logic              bk_loading,
  output logic              bk_busy,
  output logic              sav_pending,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  localparam logic [63:0] SLOT_BLKS = 64'd1 << BLK_W;

  state_t state, state_n;

  logic dl_q, ld_q, sv_q, as_q, ack_q;
  logic mode_ld;
  logic [BLK_W-1:0] blk, last;

  logic as_cond, dl_rise, arm, pend_set;
  logic auto_edge, load_edge, save_edge;
  logic ack_rise, ack_fall;
  logic start, is_ld, adv, fin, abort;

  logic [SLOT_W-1:0] slot_c, slot_s;
  logic [63:0] img_blks, base64, avail;
  logic ld_zero;
  logic [BLK_W-1:0] ld_last;

`ifdef BRAM_WDOG_EN
  logic [23:0] wd_cnt;
  logic        wd_hit;
`endif

  assign as_cond   = sav_pending & osd_status & autosave;
  assign dl_rise   = downloading & ~dl_q;
  assign arm       = downloading & img_mounted & ~img_readonly;
  assign pend_set  = bk_change & ~osd_status;
  assign auto_edge = ~downloading & dl_q & (img_size != 64'd0);
  assign load_edge = load_req & ~ld_q;
  assign save_edge = (save_req & ~sv_q) | (as_cond & ~as_q);
  assign ack_rise  = sd.sd_ack & ~ack_q;
  assign ack_fall  = ~sd.sd_ack & ack_q;

  // Auto-load always targets slot 0; out-of-range slots clamp.
  assign slot_c = (32'(slot) >= SLOTS) ? SLOT_W'(SLOTS - 1) : slot;
  assign slot_s = auto_edge ? '0 : slot_c;
  assign base64 = 64'(slot_s) << BLK_W;

  // Image size in blocks, rounded up; load length saturates to [0, 2^BLK_W].
  assign img_blks = (img_size >> 9) + 64'(|img_size[8:0]);
  assign ld_zero  = img_blks <= base64;
  assign avail    = img_blks - base64;
  assign ld_last  = (avail >= SLOT_BLKS) ? '1 : BLK_W'(avail - 64'd1);

`ifdef BRAM_WDOG_EN
  assign wd_hit = (state != IDLE) && !(ack_rise || ack_fall) &&
                  (wd_cnt == TIMEOUT - 24'd1);
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    is_ld   = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bk_ena) begin
          if (auto_edge || load_edge) begin
            start = 1'b1;
            is_ld = 1'b1;
          end else if (save_edge) begin
            start = 1'b1;
          end
        end
        if (start && !(is_ld && ld_zero)) state_n = REQ;
      end
      REQ: if (ack_rise) state_n = ACK;
      ACK: begin
        if (ack_fall) begin
          if (blk == last) begin
            state_n = IDLE;
            fin     = 1'b1;
          end else begin
            state_n = REQ;
            adv     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef BRAM_WDOG_EN
    if (wd_hit) begin
      state_n = IDLE;
      fin     = 1'b0;
      adv     = 1'b0;
      abort   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q        <= 1'b0;
      ld_q        <= 1'b0;
      sv_q        <= 1'b0;
      as_q        <= 1'b0;
      ack_q       <= 1'b0;
      bk_ena      <= 1'b0;
      sav_pending <= 1'b0;
      bk_busy     <= 1'b0;
      bk_loading  <= 1'b0;
      done        <= 1'b0;
      mode_ld     <= 1'b0;
      blk         <= '0;
      last        <= '0;
      sd.sd_lba   <= '0;
      sd.sd_rd    <= 1'b0;
      sd.sd_wr    <= 1'b0;
    end else begin
      dl_q  <= downloading;
      ld_q  <= load_req;
      sv_q  <= save_req;
      as_q  <= as_cond;
      ack_q <= sd.sd_ack;

      if (arm)          bk_ena <= 1'b1;
      else if (dl_rise) bk_ena <= 1'b0;

      // An aborted save leaves the BRAM contents still unsaved.
      if (pend_set || (abort && !mode_ld)) sav_pending <= 1'b1;
      else if (start)                      sav_pending <= 1'b0;

      done <= fin || (start && is_ld && ld_zero);

      if (start) begin
        mode_ld <= is_ld;
        blk     <= '0;
        last    <= is_ld ? ld_last : '1;
        if (state_n == REQ) begin
          sd.sd_lba  <= 32'(base64);
          bk_busy    <= 1'b1;
          bk_loading <= is_ld;
          sd.sd_rd   <= is_ld;
          sd.sd_wr   <= ~is_ld;
        end
      end

      if (state == REQ && ack_rise) begin
        sd.sd_rd <= 1'b0;
        sd.sd_wr <= 1'b0;
      end

      if (adv) begin
        blk       <= blk + BLK_W'(1);
        sd.sd_lba <= sd.sd_lba + 32'd1;
        sd.sd_rd  <= mode_ld;
        sd.sd_wr  <= ~mode_ld;
      end

      if (fin || abort) begin
        bk_busy    <= 1'b0;
        bk_loading <= 1'b0;
      end

      if (abort) begin
        sd.sd_rd <= 1'b0;
        sd.sd_wr <= 1'b0;
      end
    end
  end

`ifdef BRAM_WDOG_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE || ack_rise || ack_fall) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + 24'd1;
      if (abort)      err <= 1'b1;
      else if (start) err <= 1'b0;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{TIMEOUT, abort};
  assign err = 1'b0;
`endif

endmodule
